// File: rtl/branch_cond_unit.sv
// Per-cycle branch condition evaluation for a group of LANES instructions against NZCV flags.
// Produces registered execute/squash masks, taken-branch info, committed flags and a taken counter.
module branch_cond_unit #(
    parameter int unsigned LANES = 2,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned TL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flag_we,
    input  logic [3:0]           flag_in,
    input  logic [LANES-1:0]     in_valid,
    input  logic [4*LANES-1:0]   in_cond,
    input  logic [LANES-1:0]     in_branch,
    output logic [LANES-1:0]     out_exec,
    output logic [LANES-1:0]     out_squash,
    output logic                 out_taken,
    output logic [TL_W-1:0]      out_taken_lane,
    output logic [3:0]           ccr,
    output logic [CNT_W-1:0]     taken_count
);

    // Flag order is {N,Z,C,V} = [3:0].
    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        unique case (c)
            4'b0000: cond_true = z;
            4'b0001: cond_true = !z;
            4'b0010: cond_true = cy;
            4'b0011: cond_true = !cy;
            4'b0100: cond_true = n;
            4'b0101: cond_true = !n;
            4'b0110: cond_true = v;
            4'b0111: cond_true = !v;
            4'b1000: cond_true = cy & !z;
            4'b1001: cond_true = !cy | z;
            4'b1010: cond_true = (n == v);
            4'b1011: cond_true = (n != v);
            4'b1100: cond_true = !z & (n == v);
            4'b1101: cond_true = z | (n != v);
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    logic [3:0]       w_flags;
    logic [LANES-1:0] w_exec;
    logic [LANES-1:0] w_squash;
    logic             w_taken;
    logic [TL_W-1:0]  w_taken_lane;

    logic [LANES-1:0] r_exec;
    logic [LANES-1:0] r_squash;
    logic             r_taken;
    logic [TL_W-1:0]  r_taken_lane;
    logic [3:0]       r_ccr;
    logic [CNT_W-1:0] r_cnt;

    assign w_flags = flag_we ? flag_in : r_ccr;

    // Scan oldest to youngest; once a taken branch is seen, every younger lane is killed.
    always_comb begin
        logic v_kill;
        logic v_pass;
        v_kill       = 1'b0;
        w_exec       = '0;
        w_squash     = '0;
        w_taken_lane = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            v_pass      = in_valid[i] & cond_true(in_cond[4*i +: 4], w_flags);
            w_exec[i]   = v_pass & ~v_kill;
            w_squash[i] = in_valid[i] & v_kill;
            if (v_pass && in_branch[i] && !v_kill) begin
                v_kill       = 1'b1;
                w_taken_lane = TL_W'(i);
            end
        end
        w_taken = v_kill;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec       <= '0;
            r_squash     <= '0;
            r_taken      <= 1'b0;
            r_taken_lane <= '0;
            r_ccr        <= '0;
            r_cnt        <= '0;
        end else if (!stall) begin
            r_exec       <= w_exec;
            r_squash     <= w_squash;
            r_taken      <= w_taken;
            r_taken_lane <= w_taken_lane;
            if (flag_we) begin
                r_ccr <= flag_in;
            end
            if (w_taken && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_exec       = r_exec;
    assign out_squash     = r_squash;
    assign out_taken      = r_taken;
    assign out_taken_lane = r_taken_lane;
    assign ccr            = r_ccr;
    assign taken_count    = r_cnt;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit (LANES=2, CNT_W=4): directed scenarios then random groups.
module tb_branch_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       flag_we;
    logic [3:0] flag_in;
    logic [1:0] in_valid;
    logic [7:0] in_cond;
    logic [1:0] in_branch;
    logic [1:0] out_exec;
    logic [1:0] out_squash;
    logic       out_taken;
    logic [0:0] out_taken_lane;
    logic [3:0] ccr;
    logic [3:0] taken_count;

    typedef struct packed {
        logic [1:0] exec;
        logic [1:0] squash;
        logic       taken;
        logic       tl;
        logic [3:0] ccr;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m_prev;
    logic [3:0] m_ccr;
    logic [3:0] m_cnt;
    int n_cmp = 0;
    int n_fail = 0;

    branch_cond_unit #(.LANES(2), .CNT_W(4)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flag_we        (flag_we),
        .flag_in        (flag_in),
        .in_valid       (in_valid),
        .in_cond        (in_cond),
        .in_branch      (in_branch),
        .out_exec       (out_exec),
        .out_squash     (out_squash),
        .out_taken      (out_taken),
        .out_taken_lane (out_taken_lane),
        .ccr            (ccr),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference condition table, flags {N,Z,C,V}.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return ~z;
            4'd2:  return cf;
            4'd3:  return ~cf;
            4'd4:  return n;
            4'd5:  return ~n;
            4'd6:  return v;
            4'd7:  return ~v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n ~^ v;
            4'd11: return n ^ v;
            4'd12: return !z && (n ~^ v);
            4'd13: return z || (n ^ v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input logic rst, input logic st, input logic fwe, input logic [3:0] fin,
                        input logic [1:0] v, input logic [7:0] c, input logic [1:0] br);
        exp_t e;
        exp_t got;
        logic [3:0] f;
        logic hit;
        logic p;
        reset = rst; stall = st; flag_we = fwe; flag_in = fin;
        in_valid = v; in_cond = c; in_branch = br;
        e = '0;
        if (rst) begin
            m_ccr = 4'd0;
            m_cnt = 4'd0;
        end else if (st) begin
            e = m_prev;
        end else begin
            f = fwe ? fin : m_ccr;
            hit = 1'b0;
            for (int i = 0; i < 2; i++) begin
                p = v[i] && ref_cond(c[4*i +: 4], f);
                if (hit) begin
                    e.squash[i] = v[i];
                end else begin
                    e.exec[i] = p;
                    if (p && br[i]) begin
                        hit  = 1'b1;
                        e.tl = (i == 1);
                    end
                end
            end
            e.taken = hit;
            if (hit && m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
            if (fwe) m_ccr = fin;
            e.ccr = m_ccr;
            e.cnt = m_cnt;
        end
        m_prev = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            got = '{exec: out_exec, squash: out_squash, taken: out_taken,
                    tl: out_taken_lane[0], ccr: ccr, cnt: taken_count};
            check("exec", 32'(got.exec), 32'(e.exec));
            check("squash", 32'(got.squash), 32'(e.squash));
            check("taken", 32'(got.taken), 32'(e.taken));
            check("taken_lane", 32'(got.tl), 32'(e.tl));
            check("ccr", 32'(got.ccr), 32'(e.ccr));
            check("taken_count", 32'(got.cnt), 32'(e.cnt));
        end
    endtask

    initial begin
        m_prev = '0; m_ccr = '0; m_cnt = '0;
        // Reset state
        step(1, 0, 0, 4'h0, 2'b00, 8'h00, 2'b00);
        check("rst_all", {out_exec, out_squash, out_taken, out_taken_lane, ccr, taken_count}, 0);

        // Z set, lane0 EQ branch taken, lane1 AL squashed
        step(0, 0, 1, 4'b0100, 2'b00, 8'h00, 2'b00);
        step(0, 0, 0, 4'h0, 2'b11, {4'b1110, 4'b0000}, 2'b01);
        check("z_taken", out_taken, 1);
        check("z_lane", out_taken_lane, 0);
        check("z_exec", out_exec, 2'b01);
        check("z_squash", out_squash, 2'b10);
        check("z_cnt", taken_count, 1);

        // Flag bypass in the same group
        step(1, 0, 0, 4'h0, 2'b00, 8'h00, 2'b00);
        step(0, 0, 1, 4'b0100, 2'b01, 8'h00, 2'b01);
        check("byp_taken", out_taken, 1);
        check("byp_ccr", ccr, 4'b0100);

        // N=1,V=0: LT non-branch executes, GE branch fails
        step(0, 0, 1, 4'b1000, 2'b00, 8'h00, 2'b00);
        step(0, 0, 0, 4'h0, 2'b11, {4'b1010, 4'b1011}, 2'b10);
        check("nv_exec", out_exec, 2'b01);
        check("nv_taken", out_taken, 0);
        check("nv_squash", out_squash, 2'b00);

        // Stall for 3 cycles with taken branch and flag write pending
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 4'b0100, 2'b01, {4'b0000, 4'b1110}, 2'b01);
            check("stall_ccr", ccr, 4'b1000);
            check("stall_taken", out_taken, 0);
        end
        step(0, 0, 1, 4'b0100, 2'b01, {4'b0000, 4'b1110}, 2'b01);
        check("unstall_taken", out_taken, 1);
        check("unstall_ccr", ccr, 4'b0100);

        // Reset beats stall and flag_we; NV never taken
        step(1, 1, 1, 4'hf, 2'b11, 8'hee, 2'b11);
        check("rst_prio", {out_exec, out_squash, out_taken, out_taken_lane, ccr, taken_count}, 0);
        step(0, 0, 0, 4'h0, 2'b11, {4'b1110, 4'b1111}, 2'b11);
        check("nv_lane", out_taken_lane, 1);
        check("nv_exec1", out_exec, 2'b10);

        // Counter saturation at 15
        step(1, 0, 0, 4'h0, 2'b00, 8'h00, 2'b00);
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0, 4'h0, 2'b01, 8'h0e, 2'b01);
            check("sat_cnt", taken_count, (k > 15) ? 15 : k);
        end

        // Random groups
        for (int k = 0; k < 200; k++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
                 4'($urandom), 2'($urandom), 8'($urandom), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 The block SHALL provide parameter LANES, default 2, giving the number of instructions evaluated per cycle (legal 1..4).
REQ-002 The block SHALL provide parameter CNT_W, default 16, giving the width of the taken-branch counter.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high; clears all state.
REQ-006 stall  input  1  freezes all registers while high.
REQ-007 flag_we  input  1  flag-setting instruction writes NZCV this cycle.
REQ-008 flag_in  input  4  new flags, bit order {N,Z,C,V} = [3:0].
REQ-009 in_valid  input  LANES  per-lane instruction valid; lane 0 is oldest.
REQ-010 in_cond  input  4*LANES  per-lane condition field; lane i occupies bits [4i+3:4i].
REQ-011 in_branch  input  LANES  per-lane "instruction is a branch" flag.
REQ-012 out_exec  output  LANES  registered per-lane execute-enable.
REQ-013 out_squash  output  LANES  registered per-lane kill for lanes younger than a taken branch.
REQ-014 out_taken  output  1  registered: a branch was taken in this group.
REQ-015 out_taken_lane  output  max(1,clog2(LANES))  registered index of the taken lane; 0 when out_taken=0.
REQ-016 ccr  output  4  current committed flag register {N,Z,C,V}.
REQ-017 taken_count  output  CNT_W  saturating count of taken branches.

Function
REQ-018 Condition decode SHALL be: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 true; 1111 false.
REQ-019 Evaluation flags SHALL be flag_in when flag_we=1 in the same cycle (bypass), else ccr.
REQ-020 All lanes in a group SHALL be evaluated against the same flag value; there is no intra-group flag update.
REQ-021 pass[i] SHALL be in_valid[i] & cond_true(in_cond[i]); the cond_true term applies to every lane (predication), branch or not.
REQ-022 The taken lane T SHALL be the lowest-index lane with pass[i] & in_branch[i]; if no such lane exists, taken SHALL be 0.
REQ-023 For i<=T, or when taken=0, next out_exec[i] SHALL be pass[i] and next out_squash[i] SHALL be 0.
REQ-024 For i>T, next out_exec[i] SHALL be 0 and next out_squash[i] SHALL be in_valid[i].
REQ-025 Latency: outputs SHALL be registered, updating on the clk edge after the inputs are sampled (1 cycle).
REQ-026 ccr SHALL load flag_in on the edge after flag_we=1, and hold otherwise.
REQ-027 taken_count SHALL increment by 1 on each edge where taken=1, and SHALL hold at 2^CNT_W-1 with no wrap.
REQ-028 While stall=1, all registers SHALL hold: outputs, ccr and counter. Inputs, including flag_we, SHALL be ignored that cycle.
REQ-029 Invalid lanes SHALL never assert out_exec, and SHALL never assert out_squash.
REQ-030 Condition 1111 SHALL never execute or take, even with in_branch=1.

Reset
REQ-031 On a reset edge, out_exec, out_squash, out_taken, out_taken_lane, ccr and taken_count SHALL all go to 0.
REQ-032 Reset SHALL have priority over stall and flag_we.
REQ-033 A reset asserted mid-stream SHALL discard the in-flight group; the first group after reset deasserts SHALL be evaluated against ccr=0000 unless bypassed.
REQ-034 Combinational evaluation SHALL depend only on current inputs and ccr.

Verification
REQ-035 Bench: ccr=0100 (Z), LANES=2, lane0 {valid,cond=0000,branch}, lane1 {valid,cond=1110} -> out_taken=1, out_taken_lane=0, out_exec=01, out_squash=10, taken_count=1.
REQ-036 Bench: ccr=0000, flag_we=1, flag_in=0100, lane0 cond=0000 branch -> taken the same group (bypass); ccr=0100 after the edge.
REQ-037 Bench: flags N=1,V=0, lane0 cond=1011 non-branch, lane1 cond=1010 branch -> out_exec=01, out_taken=0, out_squash=00.
REQ-038 Bench: stall=1 for 3 cycles with a taken branch and flag_we=1 present -> outputs, ccr and counter unchanged; update occurs on the first non-stall edge.
REQ-039 Bench: CNT_W=4, 20 consecutive taken groups -> taken_count reaches 15 and holds at 15.
REQ-040 Bench: reset asserted together with stall=1 and flag_we=1 -> all outputs 0 and ccr=0000 on the next edge; lane with cond=1111 branch -> never taken.
